// File: rtl/alu_share_arbiter_if.sv
// Purpose: request, response and ALU-side signal bundle for alu_share_arbiter.
// Latency: none, wires only.
// Backpressure: carries valid/ready on both request channels and the response channel.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 8
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic [1:0]           req0_op;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;
    logic [1:0]           req1_op;

    logic                 resp_valid;
    logic                 resp_ready;
    logic                 resp_id;
    logic [2*WIDTH-1:0]   resp_data;
    logic                 resp_err;

    logic                 busy;

    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic [1:0]           alu_sel;
    logic [WIDTH:0]       alu_sum;
    logic [WIDTH-1:0]     alu_sub;
    logic [2*WIDTH-1:0]   alu_mul;
    logic [WIDTH-1:0]     alu_div;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  resp_ready,
        input  alu_sum, alu_sub, alu_mul, alu_div,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_data, resp_err,
        output busy,
        output alu_a, alu_b, alu_sel
    );

    // Clients, consumer and ALU side.
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output resp_ready,
        output alu_sum, alu_sub, alu_mul, alu_div,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_data, resp_err,
        input  busy,
        input  alu_a, alu_b, alu_sel
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin share of one combinational ALU between two requesters.
// Latency: accept at T, resp_valid at T+2, next accept at T+3 (1 op / 3 cycles).
// Backpressure: resp_ready low parks the block in RESP; no request is accepted meanwhile.
module alu_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    state_t               state;
    logic                 rr_ptr;
    logic                 lat_id;
    logic                 busy_q;
    logic [WIDTH-1:0]     alu_a_q;
    logic [WIDTH-1:0]     alu_b_q;
    logic [1:0]           alu_sel_q;
    logic                 resp_valid_q;
    logic                 resp_id_q;
    logic [2*WIDTH-1:0]   resp_data_q;
    logic                 resp_err_q;

    logic                 grant_vld;
    logic                 grant_id;
    logic                 accept;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;
    logic [1:0]           sel_op;
    logic                 div_zero;
    logic [2*WIDTH-1:0]   result;

    // rr_ptr owner first, otherwise fall back to the other requester.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = rr_ptr;
        if (rr_ptr ? bus.req1_valid : bus.req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = rr_ptr;
        end else if (rr_ptr ? bus.req0_valid : bus.req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~rr_ptr;
        end
    end

    // Gating with rst keeps both readies low in a reset cycle.
    assign accept         = !rst && (state == IDLE) && grant_vld;
    assign bus.req0_ready = accept && !grant_id;
    assign bus.req1_ready = accept &&  grant_id;

    assign sel_a  = grant_id ? bus.req1_a  : bus.req0_a;
    assign sel_b  = grant_id ? bus.req1_b  : bus.req0_b;
    assign sel_op = grant_id ? bus.req1_op : bus.req0_op;

    assign div_zero = (alu_sel_q == OP_DIV) && (alu_b_q == '0);

    always_comb begin
        result = '0;
        unique case (alu_sel_q)
            OP_ADD: result = {{(WIDTH-1){1'b0}}, bus.alu_sum};
            OP_SUB: result = {{WIDTH{1'b0}}, bus.alu_sub};
            OP_MUL: result = bus.alu_mul;
            OP_DIV: result = div_zero ? '0 : {{WIDTH{1'b0}}, bus.alu_div};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            lat_id       <= 1'b0;
            busy_q       <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        // The ALU operand registers double as the request latch.
                        alu_a_q   <= sel_a;
                        alu_b_q   <= sel_b;
                        alu_sel_q <= sel_op;
                        lat_id    <= grant_id;
                        busy_q    <= 1'b1;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data_q  <= result;
                    resp_err_q   <= div_zero;
                    resp_id_q    <= lat_id;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        rr_ptr       <= ~lat_id;
                        busy_q       <= 1'b0;
                        alu_a_q      <= '0;
                        alu_b_q      <= '0;
                        alu_sel_q    <= '0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: vector table plus contention, stall and reset sequences,
// with a response scoreboard checking order, payload, latency and hold-while-stalled.
module tb_alu_share_arbiter;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(W)) bus();

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference ALU; divide by zero returns all ones so the arbiter must mask it.
    assign bus.alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    assign bus.alu_sub = bus.alu_a - bus.alu_b;
    assign bus.alu_mul = {8'd0, bus.alu_a} * {8'd0, bus.alu_b};
    assign bus.alu_div = (bus.alu_b == 8'd0) ? 8'hFF : bus.alu_a / bus.alu_b;

    typedef struct {
        logic        id;
        logic [15:0] data;
        logic        err;
        int          hs_cyc;
    } exp_t;

    typedef struct {
        logic        id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [1:0]  op;
        logic [15:0] data;
        logic        err;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[10];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic        prev_rv = 1'b0;
    logic        prev_rr = 1'b0;
    logic        prev_id = 1'b0;
    logic        prev_err = 1'b0;
    logic [15:0] prev_data = 16'd0;

    always @(negedge clk) begin
        if (rst) begin
            prev_rv <= 1'b0;
            prev_rr <= 1'b0;
        end else begin
            if (prev_rv && !prev_rr) begin
                chk("hold_valid", bus.resp_valid, 1);
                chk("hold_data",  bus.resp_data,  prev_data);
                chk("hold_id",    bus.resp_id,    prev_id);
                chk("hold_err",   bus.resp_err,   prev_err);
            end
            if (bus.resp_valid && !prev_rv) begin
                if (exp_q.size() == 0) chk("spurious_resp", 1, 0);
                else                   chk("latency", cyc, exp_q[0].hs_cyc + 2);
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_id",   bus.resp_id,   mon_e.id);
                    chk("resp_data", bus.resp_data, mon_e.data);
                    chk("resp_err",  bus.resp_err,  mon_e.err);
                end
            end
            prev_rv   <= bus.resp_valid;
            prev_rr   <= bus.resp_ready;
            prev_id   <= bus.resp_id;
            prev_err  <= bus.resp_err;
            prev_data <= bus.resp_data;
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic drive(input logic id, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] op);
        if (id) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    task automatic push_exp(input logic id, input logic [15:0] d, input logic e);
        exp_t x;
        x.id = id; x.data = d; x.err = e; x.hs_cyc = cyc;
        exp_q.push_back(x);
    endtask

    task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [15:0] ed, input logic ee);
        bit done = 0;
        drive(id, 1'b1, a, b, op);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) begin
                push_exp(id, ed, ee);
                done = 1;
            end
            @(posedge clk); #1;
        end
        chk("accept_timeout", done, 1);
        drive(id, 1'b0, a, b, op);
    endtask

    task automatic issue_both(input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] op0,
                              input logic [15:0] d0, input logic [7:0] a1, input logic [7:0] b1,
                              input logic [1:0] op1, input logic [15:0] d1, input int exp_first);
        bit g0 = 0;
        bit g1 = 0;
        int first = -1;
        drive(1'b0, 1'b1, a0, b0, op0);
        drive(1'b1, 1'b1, a1, b1, op1);
        for (int i = 0; i < 40 && !(g0 && g1); i++) begin
            @(negedge clk);
            chk("one_ready", bus.req0_ready & bus.req1_ready, 0);
            if (bus.req0_ready && !g0) begin
                push_exp(1'b0, d0, 1'b0); g0 = 1; if (first < 0) first = 0;
            end
            if (bus.req1_ready && !g1) begin
                push_exp(1'b1, d1, 1'b0); g1 = 1; if (first < 0) first = 1;
            end
            @(posedge clk); #1;
            if (g0) bus.req0_valid = 1'b0;
            if (g1) bus.req1_valid = 1'b0;
        end
        chk("both_served", {30'd0, g1, g0}, 3);
        chk("first_grant", first, exp_first);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vecs[0] = '{1'b0, 8'd200, 8'd100, 2'b00, 16'd300,   1'b0};
        vecs[1] = '{1'b0, 8'd200, 8'd100, 2'b01, 16'd100,   1'b0};
        vecs[2] = '{1'b0, 8'd200, 8'd100, 2'b10, 16'd20000, 1'b0};
        vecs[3] = '{1'b0, 8'd200, 8'd100, 2'b11, 16'd2,     1'b0};
        vecs[4] = '{1'b1, 8'd5,   8'd10,  2'b01, 16'd251,   1'b0};
        vecs[5] = '{1'b1, 8'd9,   8'd0,   2'b11, 16'd0,     1'b1};
        vecs[6] = '{1'b1, 8'd255, 8'd255, 2'b00, 16'd510,   1'b0};
        vecs[7] = '{1'b0, 8'd255, 8'd255, 2'b10, 16'd65025, 1'b0};
        vecs[8] = '{1'b0, 8'd7,   8'd3,   2'b11, 16'd2,     1'b0};
        vecs[9] = '{1'b1, 8'd0,   8'd1,   2'b01, 16'd255,   1'b0};

        rst = 1'b1;
        bus.resp_ready = 1'b1;
        drive(1'b0, 1'b1, 8'd3, 8'd4, 2'b10);
        drive(1'b1, 1'b1, 8'd7, 8'd1, 2'b00);

        // Reset held two cycles with both requests pending.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ready0",    bus.req0_ready, 0);
            chk("rst_ready1",    bus.req1_ready, 0);
            chk("rst_resp_vld",  bus.resp_valid, 0);
            chk("rst_resp_id",   bus.resp_id,    0);
            chk("rst_resp_data", bus.resp_data,  0);
            chk("rst_resp_err",  bus.resp_err,   0);
            chk("rst_busy",      bus.busy,       0);
            chk("rst_alu",       {bus.alu_a, bus.alu_b, 6'd0, bus.alu_sel}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Contention straight out of reset: requester 0 first.
        issue_both(8'd3, 8'd4, 2'b10, 16'd12, 8'd7, 8'd1, 2'b00, 16'd8, 0);
        drain();

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].data, vecs[i].err);
            drain();
            chk("idle_busy", bus.busy, 0);
            chk("idle_alu",  {bus.alu_a, bus.alu_b, 6'd0, bus.alu_sel}, 0);
        end

        // Serve requester 0 alone so rr_ptr points at 1, then contend again.
        issue(1'b0, 8'd5, 8'd5, 2'b00, 16'd10, 1'b0);
        drain();
        issue_both(8'd10, 8'd3, 2'b01, 16'd7, 8'd6, 8'd7, 2'b10, 16'd42, 1);
        drain();

        // Back-pressure: park in RESP with requester 1 waiting.
        bus.resp_ready = 1'b0;
        issue(1'b0, 8'd10, 8'd20, 2'b00, 16'd30, 1'b0);
        drive(1'b1, 1'b1, 8'd50, 8'd2, 2'b11);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = bus.resp_valid;
        end
        chk("bp_resp_seen", ok, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_busy",     bus.busy,       1);
            chk("bp_ready0",   bus.req0_ready, 0);
            chk("bp_ready1",   bus.req1_ready, 0);
            chk("bp_resp_vld", bus.resp_valid, 1);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready1", bus.req1_ready, 0);
        @(negedge clk);
        chk("bp_next_accept", bus.req1_ready, 1);
        if (bus.req1_ready) push_exp(1'b1, 16'd25, 1'b0);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        drain();

        // Reset during EXEC drops the request; pending requester 1 goes next.
        issue(1'b0, 8'd1, 8'd2, 2'b00, 16'd3, 1'b0);
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'd4, 8'd4, 2'b10);
        @(negedge clk);
        chk("mid_rst_ready0", bus.req0_ready, 0);
        chk("mid_rst_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_dropped", exp_q.size(), 1);
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        @(negedge clk);
        chk("mid_rst_resp_vld", bus.resp_valid, 0);
        chk("mid_rst_busy",     bus.busy,       0);
        chk("mid_rst_reaccept", bus.req1_ready, 1);
        if (bus.req1_ready) push_exp(1'b1, 16'd16, 1'b0);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (add/sub/mul/div) between two requesters using round-robin arbitration.
- Each requester sends an operand pair and an opcode over a valid/ready handshake.
- The block registers the winning request, drives the ALU, captures and selects the result, then returns it over a valid/ready response channel tagged with the requester ID.
- Sits between two client engines and the shared alu instance in the ALU subsystem.

Parameters:
- WIDTH, 8, operand width in bits. All arithmetic is unsigned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand a.
- req0_b  in  WIDTH  requester 0 operand b.
- req0_op  in  2  requester 0 opcode: 00 add, 01 sub, 10 mul, 11 div.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  1  requester that owns the response.
- resp_data  out  2*WIDTH  result, zero-extended.
- resp_err  out  1  divide-by-zero flag.
- busy  out  1  high whenever state is not IDLE.
- alu_a  out  WIDTH  ALU operand a.
- alu_b  out  WIDTH  ALU operand b.
- alu_sel  out  2  ALU operation select.
- alu_sum  in  WIDTH+1  ALU a+b, including carry.
- alu_sub  in  WIDTH  ALU a-b, modulo 2^WIDTH.
- alu_mul  in  2*WIDTH  ALU a*b.
- alu_div  in  WIDTH  ALU a/b.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- Reset values:
  - state = IDLE, rr_ptr = 0 (requester 0 has priority).
  - resp_valid = 0, resp_id = 0, resp_data = 0, resp_err = 0.
  - busy = 0; alu_a, alu_b, alu_sel = 0.
- Reset mid-operation: reset in any state wins. The in-flight request is dropped with no response, and no ready is asserted in that cycle.
- Arbitration (IDLE only):
  - grant = requester rr_ptr if its valid is high, else the other requester if its valid is high.
  - reqN_ready = (state==IDLE) && grant==N. This is combinational, so at most one ready is high per cycle.
  - On a handshake (valid&&ready), latch a, b, op and id, then go to EXEC.
- Ready rule: ready is never high outside IDLE. Requesters hold valid and payload stable until ready.
- EXEC (exactly one cycle):
  - alu_a, alu_b, alu_sel are driven from the latched registers. They hold those values through EXEC and RESP and return to 0 in IDLE.
  - At the end of EXEC, resp_data captures the result selected by the latched op:
    - add: zero-extended alu_sum.
    - sub: zero-extended alu_sub.
    - mul: alu_mul.
    - div: zero-extended alu_div.
  - Divide by zero (op=11, b=0): resp_data = 0 and resp_err = 1; alu_div is ignored. Otherwise resp_err = 0.
- Transition to RESP: resp_valid rises, and resp_id equals the latched id.
- RESP:
  - resp_valid, resp_id, resp_data and resp_err hold stable until resp_ready.
  - On resp_valid && resp_ready: resp_valid drops next cycle, state returns to IDLE, and rr_ptr = ~served id.
- Latency: handshake in cycle T, resp_valid high at T+2. With resp_ready held high, the next accept is at T+3, giving a throughput of 1 op per 3 cycles.
- Simultaneous requests: the requester pointed to by rr_ptr wins. The loser keeps valid high and is granted on the next IDLE cycle, so it cannot starve.
- A single requester may be served back-to-back even when rr_ptr points to the idle requester.
- Back-pressure: resp_ready held low stalls the block in RESP indefinitely, and no new request is accepted.

Test Plan (WIDTH=8):
- Reset: assert rst for 2 cycles with both valids high -> all outputs 0, both readies 0 during reset, and the first grant after reset goes to requester 0.
- Single op: req0 a=200, b=100, add at T -> resp_valid at T+2 with resp_data=300, resp_id=0, resp_err=0. Repeat for sub (resp_data 100), mul (20000) and div (2).
- Wrap and error: req1 a=5, b=10, sub -> resp_data=251. Then a=9, b=0, div -> resp_data=0, resp_err=1.
- Contention: both valid at once; req0 a=3, b=4 mul; req1 a=7, b=1 add -> first response id 0 data 12, second id 1 data 8. Repeat the simultaneous request with new payloads -> requester 1 is served first.
- Back-pressure: hold resp_ready=0 for 5 cycles in RESP -> response stable, busy=1, both readies 0. Release -> completes and the block accepts the next request 1 cycle later.
- Reset mid-op: assert rst during EXEC -> no resp_valid, state IDLE, pending valid re-accepted after reset.
